// File: rtl/out_port_fifo.sv
// out_port_fifo: output-port buffer between the CPU write-back stage and the
// external O_Port pins. Circular-buffer FIFO with a fall-through valid/ready
// output. O_Port holds the last consumed value while the queue is empty.
// Optional sticky overflow flag enabled by defining OUTFIFO_OVF_EN; without it
// ovf is tied low and dropped writes are discarded silently.
module out_port_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             out_we,
   input  logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] O_Port,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             full,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count;
   logic [WIDTH-1:0] last_q;
   logic             empty;
   logic             push;
   logic             pop;

   // Occupancy and handshake decode from the registered pointers only
   always_comb begin
      count   = wr_ptr - rd_ptr;
      empty   = (count == '0);
      full    = (count == PW'(DEPTH));
      o_valid = !empty;
      pop     = o_valid & o_ready;
      push    = out_we & (!full | pop);
      O_Port  = o_valid ? mem[rd_ptr[AW-1:0]] : last_q;
   end

   // Pointer and last-value registers; reset flushes any queued data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            last_q <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Buffer storage; contents after reset are don't-care
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= out_data;
      end
   end

`ifdef OUTFIFO_OVF_EN
   logic drop;
   logic ovf_q;

   assign drop = out_we & full & !pop;
   assign ovf  = ovf_q;

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end
`else
   logic unused_ovf_clr;

   assign ovf            = 1'b0;
   assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// tb_out_port_fifo: directed table-driven bench for out_port_fifo (DEPTH 4).
module tb_out_port_fifo;

`ifdef OUTFIFO_OVF_EN
   localparam logic OV = 1'b1;
`else
   localparam logic OV = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       out_we = 1'b0;
   logic [7:0] out_data = 8'h00;
   logic [7:0] O_Port;
   logic       o_valid;
   logic       o_ready = 1'b0;
   logic       full;
   logic       ovf;
   logic       ovf_clr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       we;
      logic [7:0] data;
      logic       rdy;
      logic       clr;
      logic [7:0] e_port;
      logic       e_valid;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t tv[$];

   out_port_fifo #(.DEPTH(4), .WIDTH(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .out_we   (out_we),
      .out_data (out_data),
      .O_Port   (O_Port),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .full     (full),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] e_port, input logic e_valid,
                          input logic e_full, input logic e_ovf);
      chk({tag, " O_Port"}, O_Port, e_port);
      chk({tag, " o_valid"}, 8'(o_valid), 8'(e_valid));
      chk({tag, " full"}, 8'(full), 8'(e_full));
      chk({tag, " ovf"}, 8'(ovf), 8'(e_ovf));
   endtask

   // Apply inputs for one cycle, leave outputs settled 1 time unit after the edge
   task automatic step(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
      out_we   = we;
      out_data = d;
      o_ready  = rdy;
      ovf_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic we, input logic [7:0] d, input logic rdy, input logic clr,
                      input logic [7:0] ep, input logic ev, input logic ef, input logic eo);
      vec_t v;
      v.we = we; v.data = d; v.rdy = rdy; v.clr = clr;
      v.e_port = ep; v.e_valid = ev; v.e_full = ef; v.e_ovf = eo;
      tv.push_back(v);
   endtask

   initial begin
      // Single write held across idle cycles, then consumed
      add(1, 8'h0C, 0, 0, 8'h0C, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 8'h0C, 1, 0, 0);
      add(0, 8'h00, 1, 0, 8'h0C, 0, 0, 0);
      // Fill to full, drop a write, drain in order
      add(1, 8'h11, 0, 0, 8'h11, 1, 0, 0);
      add(1, 8'h12, 0, 0, 8'h11, 1, 0, 0);
      add(1, 8'h13, 0, 0, 8'h11, 1, 0, 0);
      add(1, 8'h14, 0, 0, 8'h11, 1, 1, 0);
      add(1, 8'h15, 0, 0, 8'h11, 1, 1, OV);
      add(0, 8'h00, 1, 0, 8'h12, 1, 0, OV);
      add(0, 8'h00, 1, 0, 8'h13, 1, 0, OV);
      add(0, 8'h00, 1, 0, 8'h14, 1, 0, OV);
      add(0, 8'h00, 1, 0, 8'h14, 0, 0, OV);
      add(0, 8'h00, 0, 1, 8'h14, 0, 0, 0);
      // Full, then push with a simultaneous pop
      add(1, 8'h21, 0, 0, 8'h21, 1, 0, 0);
      add(1, 8'h22, 0, 0, 8'h21, 1, 0, 0);
      add(1, 8'h23, 0, 0, 8'h21, 1, 0, 0);
      add(1, 8'h24, 0, 0, 8'h21, 1, 1, 0);
      add(1, 8'h25, 1, 0, 8'h22, 1, 1, 0);
      add(0, 8'h00, 1, 0, 8'h23, 1, 0, 0);
      add(0, 8'h00, 1, 0, 8'h24, 1, 0, 0);
      add(0, 8'h00, 1, 0, 8'h25, 1, 0, 0);
      add(0, 8'h00, 1, 0, 8'h25, 0, 0, 0);
      // o_ready while empty is ignored
      add(0, 8'h00, 1, 0, 8'h25, 0, 0, 0);

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 8'h00, 0, 0, 0);
      rstn = 1'b1;

      foreach (tv[i]) begin
         step(tv[i].we, tv[i].data, tv[i].rdy, tv[i].clr);
         chk_out($sformatf("vec%0d", i), tv[i].e_port, tv[i].e_valid, tv[i].e_full, tv[i].e_ovf);
      end

      // Streaming through pointer wrap: each value appears once, in order
      for (int i = 0; i < 20; i++) begin
         step(1, 8'(8'h30 + i), 1, 0);
         chk_out($sformatf("wrap%0d", i), 8'(8'h30 + i), 1, 0, 0);
      end
      step(0, 8'h00, 1, 0);
      chk_out("wrap_end", 8'h43, 0, 0, 0);

      // Asynchronous reset with three entries queued
      step(1, 8'h51, 0, 0);
      step(1, 8'h52, 0, 0);
      step(1, 8'h53, 0, 0);
      chk_out("pre_rst", 8'h51, 1, 0, 0);
      #2;
      rstn = 1'b0;
      #1;
      chk_out("mid_rst", 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0);
      chk_out("rst_hold", 8'h00, 0, 0, 0);
      rstn = 1'b1;

      // Overflow after recovery, clear, then drop coinciding with clear
      step(1, 8'h61, 0, 0);
      step(1, 8'h62, 0, 0);
      step(1, 8'h63, 0, 0);
      step(1, 8'h64, 0, 0);
      chk_out("refill", 8'h61, 1, 1, 0);
      step(1, 8'h65, 0, 0);
      chk_out("ovf_set", 8'h61, 1, 1, OV);
      step(0, 8'h00, 0, 1);
      chk_out("ovf_clr", 8'h61, 1, 1, 0);
      step(1, 8'h66, 0, 1);
      chk_out("set_wins", 8'h61, 1, 1, OV);
      step(0, 8'h00, 1, 0);
      chk_out("post_drop", 8'h62, 1, 0, OV);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
